// File: rtl/tsc_pkg.sv
// Shared types and default timing for the traffic phase scheduler.
// Holds the phase encoding, lamp bundle, dwell-counter width, default
// dwell constants and the phase-to-lamp decode used by the scheduler.
package tsc_pkg;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned PHASE_W = 3;

    localparam int unsigned DEF_T_MIN_GREEN  = 8;
    localparam int unsigned DEF_T_MAX_GREEN  = 20;
    localparam int unsigned DEF_T_YELLOW     = 3;
    localparam int unsigned DEF_T_ALL_RED    = 2;
    localparam int unsigned DEF_T_WALK       = 6;
    localparam int unsigned DEF_T_WALK_CLEAR = 4;

    // Direction of the most recent vehicle green
    localparam logic DIR_N = 1'b0;
    localparam logic DIR_E = 1'b1;

    typedef enum logic [PHASE_W-1:0] {
        ALL_RED    = 3'd0,
        N_GREEN    = 3'd1,
        N_YELLOW   = 3'd2,
        E_GREEN    = 3'd3,
        E_YELLOW   = 3'd4,
        WALK       = 3'd5,
        WALK_CLEAR = 3'd6
    } phase_e;

    typedef struct packed {
        logic north_green;
        logic north_yellow;
        logic north_red;
        logic east_green;
        logic east_yellow;
        logic east_red;
        logic walk_green;
        logic walk_red;
    } lamps_t;

    // Lamp pattern for a phase; every non-serving signal head shows red
    function automatic lamps_t lamp_decode(input phase_e ph);
        lamps_t l;
        l           = '0;
        l.north_red = 1'b1;
        l.east_red  = 1'b1;
        l.walk_red  = 1'b1;
        case (ph)
            N_GREEN:  begin l.north_red = 1'b0; l.north_green  = 1'b1; end
            N_YELLOW: begin l.north_red = 1'b0; l.north_yellow = 1'b1; end
            E_GREEN:  begin l.east_red  = 1'b0; l.east_green   = 1'b1; end
            E_YELLOW: begin l.east_red  = 1'b0; l.east_yellow  = 1'b1; end
            WALK:     begin l.walk_red  = 1'b0; l.walk_green   = 1'b1; end
            default:  ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the phase scheduler.
// Ports: clk, rst_n (async active-low), clr_i (phase entry, clears count),
// tick_i (time-base strobe), term_i (last count of the current phase),
// cnt_o (registered count; holds once it reaches term_i).
module dwell_timer
    import tsc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on entry, advance on tick, saturate at terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != term_i)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/phase_scheduler.sv
// Two-direction traffic phase scheduler with pedestrian and emergency service.
// Inputs: clk, reset (async active-low), tick (time base), car_n/car_e
// (vehicle presence), ped_btn (pedestrian button), emerg_req/emerg_dir
// (preemption, dir 0 = north, 1 = east).
// Outputs: registered vehicle and walk lamps, ped_wait (latched pedestrian
// demand), phase (current state encoding).
module phase_scheduler
    import tsc_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN  = DEF_T_MIN_GREEN,
    parameter int unsigned T_MAX_GREEN  = DEF_T_MAX_GREEN,
    parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
    parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
    parameter int unsigned T_WALK       = DEF_T_WALK,
    parameter int unsigned T_WALK_CLEAR = DEF_T_WALK_CLEAR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               car_n,
    input  logic               car_e,
    input  logic               ped_btn,
    input  logic               emerg_req,
    input  logic               emerg_dir,
    output logic               NORTH_GREEN,
    output logic               NORTH_YELLOW,
    output logic               NORTH_RED,
    output logic               EAST_GREEN,
    output logic               EAST_YELLOW,
    output logic               EAST_RED,
    output logic               WALK_GREEN,
    output logic               WALK_RED,
    output logic               ped_wait,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] WC_LAST   = CNT_W'(T_WALK_CLEAR - 1);

    phase_e           state_q, state_d, grant_c;
    logic [CNT_W-1:0] cnt, term_c;
    logic             at_term_c, entry_c;
    logic             comp_n_c, comp_e_c, exit_n_c, exit_e_c;
    logic             ped_wait_q, ped_wait_d;
    logic             last_green_q, last_green_d;
    lamps_t           lamps_q, lamps_d;

    dwell_timer u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (entry_c),
        .tick_i (tick),
        .term_i (term_c),
        .cnt_o  (cnt)
    );

    // Last dwell count of the current phase; greens saturate at max green
    always_comb begin
        term_c = AR_LAST;
        case (state_q)
            N_GREEN, E_GREEN:   term_c = MAX_LAST;
            N_YELLOW, E_YELLOW: term_c = YEL_LAST;
            WALK:               term_c = WALK_LAST;
            WALK_CLEAR:         term_c = WC_LAST;
            default:            term_c = AR_LAST;
        endcase
    end

    assign at_term_c = (cnt == term_c);

    // Competing demand and green termination per direction
    assign comp_n_c = car_e | ped_wait_q;
    assign comp_e_c = car_n | ped_wait_q;
    assign exit_n_c = (emerg_req & (emerg_dir != DIR_N))
                    | (comp_n_c & ~car_n & (cnt >= MIN_LAST))
                    | (comp_n_c & at_term_c);
    assign exit_e_c = (emerg_req & (emerg_dir != DIR_E))
                    | (comp_e_c & ~car_e & (cnt >= MIN_LAST))
                    | (comp_e_c & at_term_c);

    // All-red exit choice: preemption, then walk, then round-robin
    always_comb begin
        grant_c = N_GREEN;
        if (emerg_req) begin
            grant_c = (emerg_dir == DIR_E) ? E_GREEN : N_GREEN;
        end else if (ped_wait_q) begin
            grant_c = WALK;
        end else if (last_green_q == DIR_E) begin
            grant_c = (car_n || !car_e) ? N_GREEN : E_GREEN;
        end else begin
            grant_c = car_e ? E_GREEN : N_GREEN;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        entry_c      = 1'b0;
        ped_wait_d   = ped_wait_q;
        last_green_d = last_green_q;
        lamps_d      = lamp_decode(state_q);

        if (tick) begin
            case (state_q)
                ALL_RED:    if (at_term_c)              state_d = grant_c;
                N_GREEN:    if (exit_n_c)               state_d = N_YELLOW;
                N_YELLOW:   if (at_term_c)              state_d = ALL_RED;
                E_GREEN:    if (exit_e_c)               state_d = E_YELLOW;
                E_YELLOW:   if (at_term_c)              state_d = ALL_RED;
                WALK:       if (at_term_c || emerg_req) state_d = WALK_CLEAR;
                WALK_CLEAR: if (at_term_c)              state_d = ALL_RED;
                default:                                state_d = ALL_RED;
            endcase
        end

        entry_c = (state_d != state_q);

        // Walk entry wins over a same-cycle press
        if (entry_c && (state_d == WALK)) begin
            ped_wait_d = 1'b0;
        end else if (ped_btn && (state_q != WALK) && (state_q != WALK_CLEAR)) begin
            ped_wait_d = 1'b1;
        end

        if (entry_c && (state_d == N_YELLOW)) begin
            last_green_d = DIR_N;
        end else if (entry_c && (state_d == E_YELLOW)) begin
            last_green_d = DIR_E;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ALL_RED;
            ped_wait_q   <= 1'b0;
            last_green_q <= DIR_E;
            lamps_q      <= lamp_decode(ALL_RED);
        end else begin
            state_q      <= state_d;
            ped_wait_q   <= ped_wait_d;
            last_green_q <= last_green_d;
            lamps_q      <= lamps_d;
        end
    end

    assign NORTH_GREEN  = lamps_q.north_green;
    assign NORTH_YELLOW = lamps_q.north_yellow;
    assign NORTH_RED    = lamps_q.north_red;
    assign EAST_GREEN   = lamps_q.east_green;
    assign EAST_YELLOW  = lamps_q.east_yellow;
    assign EAST_RED     = lamps_q.east_red;
    assign WALK_GREEN   = lamps_q.walk_green;
    assign WALK_RED     = lamps_q.walk_red;
    assign ped_wait     = ped_wait_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler with tick held high every cycle.
// Outputs are sampled on the falling clock edge; lamps are expected to
// show the phase observed one sample earlier.
module tb_phase_scheduler;
    import tsc_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tick, car_n, car_e, ped_btn, emerg_req, emerg_dir;
    logic       NORTH_GREEN, NORTH_YELLOW, NORTH_RED;
    logic       EAST_GREEN, EAST_YELLOW, EAST_RED;
    logic       WALK_GREEN, WALK_RED, ped_wait;
    logic [2:0] phase;
    logic [7:0] lamps;

    int     n_pass  = 0;
    int     n_total = 0;
    phase_e prev_ph = ALL_RED;

    always #5 clk = ~clk;

    phase_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .car_n        (car_n),
        .car_e        (car_e),
        .ped_btn      (ped_btn),
        .emerg_req    (emerg_req),
        .emerg_dir    (emerg_dir),
        .NORTH_GREEN  (NORTH_GREEN),
        .NORTH_YELLOW (NORTH_YELLOW),
        .NORTH_RED    (NORTH_RED),
        .EAST_GREEN   (EAST_GREEN),
        .EAST_YELLOW  (EAST_YELLOW),
        .EAST_RED     (EAST_RED),
        .WALK_GREEN   (WALK_GREEN),
        .WALK_RED     (WALK_RED),
        .ped_wait     (ped_wait),
        .phase        (phase)
    );

    assign lamps = {NORTH_GREEN, NORTH_YELLOW, NORTH_RED,
                    EAST_GREEN, EAST_YELLOW, EAST_RED,
                    WALK_GREEN, WALK_RED};

    // Hand-written lamp table {NG,NY,NR,EG,EY,ER,WG,WR}
    function automatic logic [7:0] exp_lamps(input phase_e ph);
        case (ph)
            N_GREEN:  return 8'b100_001_01;
            N_YELLOW: return 8'b010_001_01;
            E_GREEN:  return 8'b001_100_01;
            E_YELLOW: return 8'b001_010_01;
            WALK:     return 8'b001_001_10;
            default:  return 8'b001_001_01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expect phase ph on n consecutive samples, lamps lagging by one sample
    task automatic run(input phase_e ph, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s.phase[%0d]", tag, i), 8'(phase), 8'(ph));
            chk($sformatf("%s.lamps[%0d]", tag, i), lamps, exp_lamps(prev_ph));
            prev_ph = ph;
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b1; car_n = 1'b0; car_e = 1'b1;
        ped_btn = 1'b0; emerg_req = 1'b0; emerg_dir = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.phase", 8'(phase), 8'(ALL_RED));
        chk("rst.lamps", lamps, 8'b001_001_01);
        chk("rst.ped_wait", 8'(ped_wait), 8'd0);
        prev_ph = ALL_RED;
        @(negedge clk);
        reset = 1'b1;

        // Release mid-cycle: one sample of all-red, then east rests green
        run(ALL_RED, 1, "boot_ar");
        run(E_GREEN, 30, "e_rest");

        // North demand ends the rested east green at once
        car_e = 1'b0; car_n = 1'b1;
        run(E_YELLOW, 3, "e_yel1");
        car_e = 1'b1;
        run(ALL_RED, 2, "ar1");
        run(N_GREEN, 1, "n_grn");
        car_n = 1'b0;
        run(N_GREEN, 7, "n_grn");
        run(N_YELLOW, 3, "n_yel");
        run(ALL_RED, 2, "ar2");
        run(E_GREEN, 1, "e_grn2");

        // Pedestrian during east green with own car present: max green
        ped_btn = 1'b1;
        run(E_GREEN, 1, "e_grn2");
        ped_btn = 1'b0;
        chk("ped.latched", 8'(ped_wait), 8'd1);
        run(E_GREEN, 18, "e_grn2");
        run(E_YELLOW, 3, "e_yel2");
        run(ALL_RED, 2, "ar3");
        run(WALK, 1, "walk1");
        chk("ped.walk_clr", 8'(ped_wait), 8'd0);
        ped_btn = 1'b1;
        run(WALK, 1, "walk1");
        ped_btn = 1'b0;
        chk("ped.walk_drop", 8'(ped_wait), 8'd0);
        run(WALK, 4, "walk1");
        run(WALK_CLEAR, 4, "wclr1");
        run(ALL_RED, 2, "ar4");
        run(E_GREEN, 1, "e_grn3");

        // North preemption at east green tick 2 beats pending pedestrian
        ped_btn = 1'b1;
        run(E_GREEN, 1, "e_grn3");
        ped_btn = 1'b0; emerg_req = 1'b1; emerg_dir = 1'b0;
        chk("emg.ped_wait", 8'(ped_wait), 8'd1);
        run(E_YELLOW, 3, "e_yel3");
        run(ALL_RED, 2, "ar5");
        run(N_GREEN, 1, "n_emg");
        chk("emg.ped_held", 8'(ped_wait), 8'd1);

        // East preemption cuts north green; dropping it mid-yellow keeps yellow
        emerg_dir = 1'b1;
        run(N_YELLOW, 1, "n_yel2");
        emerg_req = 1'b0;
        run(N_YELLOW, 2, "n_yel2");
        run(ALL_RED, 2, "ar6");
        run(WALK, 2, "walk2");

        // Preemption shortens walk but never the clearance
        emerg_req = 1'b1;
        run(WALK_CLEAR, 4, "wclr2");
        run(ALL_RED, 2, "ar7");
        run(E_GREEN, 1, "e_emg");

        // Own car gone and pedestrian pending: min green
        emerg_req = 1'b0; ped_btn = 1'b1; car_e = 1'b0;
        run(E_GREEN, 1, "e_min");
        ped_btn = 1'b0;
        chk("min.ped_wait", 8'(ped_wait), 8'd1);
        run(E_GREEN, 6, "e_min");
        run(E_YELLOW, 3, "e_yel4");
        run(ALL_RED, 2, "ar8");
        run(WALK, 3, "walk3");

        // Asynchronous reset in the middle of walk
        #2 reset = 1'b0;
        #1;
        chk("arst.phase", 8'(phase), 8'(ALL_RED));
        chk("arst.lamps", lamps, 8'b001_001_01);
        chk("arst.walk_red", 8'(WALK_RED), 8'd1);
        chk("arst.ped_wait", 8'(ped_wait), 8'd0);
        prev_ph = ALL_RED;
        car_n = 1'b0; car_e = 1'b0;
        @(negedge clk);
        chk("arst.hold", 8'(phase), 8'(ALL_RED));
        reset = 1'b1;

        // Full all-red after release, then north by default
        run(ALL_RED, 1, "boot2_ar");
        run(N_GREEN, 2, "boot2_n");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
